// File: rtl/write_stage_param.sv
// rtl/write_stage_param.sv - writeback stage: result select, load extend, late-load stall, registered register-file write port
// Optional same-cycle forwarding port is built only when WB_FORWARD_EN is defined.
module write_stage_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              RegWrite,
  input  logic [1:0]        RegStore,
  input  logic [1:0]        LoadSize,
  input  logic [DATA_W-1:0] IPCP2,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] StoreMem,
  input  logic [DATA_W-1:0] Imm,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] rdWB,
  output logic [DATA_W-1:0] loadData,
  output logic [ADDR_W-1:0] loadAddr,
  output logic              regWriteOut,
  output logic              stall
`ifdef WB_FORWARD_EN
  ,
  output logic              fwdValid,
  output logic [ADDR_W-1:0] fwdAddr,
  output logic [DATA_W-1:0] fwdData
`endif
);

  localparam logic [1:0] SRC_MEM  = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  localparam logic [1:0] LS_ZEXT = 2'd1;
  localparam logic [1:0] LS_SEXT = 2'd2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ADDR_W-1:0] r_cap_rd;
  logic              r_cap_we;
  logic [1:0]        r_cap_size;

  logic              w_retire;
  logic              w_capture;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_en;

  // Byte loads fill the upper bits first, then overlay the low byte; LoadSize 3 behaves as full word.
  function automatic logic [DATA_W-1:0] f_extend(input logic [1:0] size,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    case (size)
      LS_ZEXT: begin
        v      = '0;
        v[7:0] = d[7:0];
      end
      LS_SEXT: begin
        v      = d[7] ? '1 : '0;
        v[7:0] = d[7:0];
      end
      default: v = d;
    endcase
    return v;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_capture    = 1'b0;
    w_wr_data    = '0;
    w_wr_addr    = '0;
    w_wr_en      = 1'b0;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if ((RegStore != SRC_MEM) || mem_valid) begin
            w_retire  = 1'b1;
            w_wr_addr = rdWB;
            w_wr_en   = RegWrite | (RegStore == SRC_LINK);
            case (RegStore)
              SRC_ALU:  w_wr_data = ALUResult;
              SRC_LINK: w_wr_data = IPCP2;
              SRC_IMM:  w_wr_data = Imm;
              default:  w_wr_data = f_extend(LoadSize, StoreMem);
            endcase
          end else begin
            w_capture    = 1'b1;
            w_next_state = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          w_retire     = 1'b1;
          w_wr_addr    = r_cap_rd;
          w_wr_en      = r_cap_we;
          w_wr_data    = f_extend(r_cap_size, StoreMem);
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    if (ZERO_REG && (w_wr_addr == '0)) begin
      w_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cap_rd   <= '0;
      r_cap_we   <= 1'b0;
      r_cap_size <= 2'd0;
    end else if (w_capture) begin
      r_cap_rd   <= rdWB;
      r_cap_we   <= RegWrite;
      r_cap_size <= LoadSize;
    end
  end

  // Address and data hold between retires; only the strobe drops back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadData    <= '0;
      loadAddr    <= '0;
      regWriteOut <= 1'b0;
      stall       <= 1'b0;
    end else begin
      regWriteOut <= w_retire & w_wr_en;
      stall       <= (w_next_state == WAIT_MEM);
      if (w_retire) begin
        loadData <= w_wr_data;
        loadAddr <= w_wr_addr;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdValid = regWriteOut;
  assign fwdAddr  = loadAddr;
  assign fwdData  = loadData;
`endif

endmodule

// File: tb/tb_write_stage_param.sv
// tb/tb_write_stage_param.sv - scoreboard bench for write_stage_param, ZERO_REG=0 and ZERO_REG=1 instances in parallel
// Forward ports are connected and checked when WB_FORWARD_EN is defined.
module tb_write_stage_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        RegWrite;
  logic [1:0]  RegStore;
  logic [1:0]  LoadSize;
  logic [15:0] IPCP2;
  logic [15:0] ALUResult;
  logic [15:0] StoreMem;
  logic [15:0] Imm;
  logic        mem_valid;
  logic [2:0]  rdWB;

  logic [15:0] d0_data, d1_data;
  logic [2:0]  d0_addr, d1_addr;
  logic        d0_we, d1_we, d0_stall, d1_stall;
`ifdef WB_FORWARD_EN
  logic        f0_v, f1_v;
  logic [2:0]  f0_a, f1_a;
  logic [15:0] f0_d, f1_d;
`endif

  always #5 clk = ~clk;

  write_stage_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RegWrite(RegWrite),
    .RegStore(RegStore), .LoadSize(LoadSize), .IPCP2(IPCP2), .ALUResult(ALUResult),
    .StoreMem(StoreMem), .Imm(Imm), .mem_valid(mem_valid), .rdWB(rdWB),
    .loadData(d0_data), .loadAddr(d0_addr), .regWriteOut(d0_we), .stall(d0_stall)
`ifdef WB_FORWARD_EN
    , .fwdValid(f0_v), .fwdAddr(f0_a), .fwdData(f0_d)
`endif
  );

  write_stage_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RegWrite(RegWrite),
    .RegStore(RegStore), .LoadSize(LoadSize), .IPCP2(IPCP2), .ALUResult(ALUResult),
    .StoreMem(StoreMem), .Imm(Imm), .mem_valid(mem_valid), .rdWB(rdWB),
    .loadData(d1_data), .loadAddr(d1_addr), .regWriteOut(d1_we), .stall(d1_stall)
`ifdef WB_FORWARD_EN
    , .fwdValid(f1_v), .fwdAddr(f1_a), .fwdData(f1_d)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [2:0]  a;
    logic        we0;
    logic        we1;
    logic        st;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: a pending late-load op (if any) plus the last write seen by the register file.
  logic        m_pend;
  logic [2:0]  m_pend_rd;
  logic        m_pend_rw;
  logic [1:0]  m_pend_ls;
  logic [15:0] m_data;
  logic [2:0]  m_addr;
  logic        m_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref_load(input logic [1:0] size, input logic [15:0] mem);
    if (size == 2'd1) return 16'(mem % 256);
    if (size == 2'd2) return (mem % 256 >= 128) ? 16'(mem % 256) + 16'hFF00 : 16'(mem % 256);
    return mem;
  endfunction

  task automatic drive(input logic rst_v, input logic iv, input logic rw,
                       input logic [1:0] rs, input logic [1:0] ls,
                       input logic [15:0] ipc, input logic [15:0] alu,
                       input logic [15:0] sm, input logic [15:0] imm,
                       input logic mv, input logic [2:0] rd);
    exp_t        e;
    logic        retire;
    logic [15:0] val;
    logic [2:0]  dst;
    logic        wr;
    @(negedge clk);
    reset = rst_v; in_valid = iv; RegWrite = rw; RegStore = rs; LoadSize = ls;
    IPCP2 = ipc; ALUResult = alu; StoreMem = sm; Imm = imm; mem_valid = mv; rdWB = rd;
    retire = 1'b0; val = '0; dst = '0; wr = 1'b0;
    if (!rst_v) begin
      m_pend = 1'b0; m_data = '0; m_addr = '0; m_we = 1'b0;
    end else begin
      if (m_pend) begin
        if (mv) begin
          retire = 1'b1; dst = m_pend_rd; wr = m_pend_rw; val = ref_load(m_pend_ls, sm);
          m_pend = 1'b0;
        end
      end else if (iv) begin
        if (rs != 2'd0 || mv) begin
          retire = 1'b1; dst = rd; wr = rw || (rs == 2'd2);
          val = (rs == 2'd1) ? alu : (rs == 2'd2) ? ipc : (rs == 2'd3) ? imm : ref_load(ls, sm);
        end else begin
          m_pend = 1'b1; m_pend_rd = rd; m_pend_rw = rw; m_pend_ls = ls;
        end
      end
      m_we = retire && wr;
      if (retire) begin
        m_data = val; m_addr = dst;
      end
    end
    e.d = m_data; e.a = m_addr; e.we0 = m_we; e.we1 = m_we && (m_addr != 3'd0);
    e.st = rst_v && m_pend;
    sb_q.push_back(e);
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("z0_loadData", 32'(d0_data), 32'(e.d));
        chk("z0_loadAddr", 32'(d0_addr), 32'(e.a));
        chk("z0_regWriteOut", 32'(d0_we), 32'(e.we0));
        chk("z0_stall", 32'(d0_stall), 32'(e.st));
        chk("z1_loadData", 32'(d1_data), 32'(e.d));
        chk("z1_loadAddr", 32'(d1_addr), 32'(e.a));
        chk("z1_regWriteOut", 32'(d1_we), 32'(e.we1));
        chk("z1_stall", 32'(d1_stall), 32'(e.st));
`ifdef WB_FORWARD_EN
        chk("z0_fwdValid", 32'(f0_v), 32'(e.we0));
        chk("z0_fwdAddr", 32'(f0_a), 32'(e.a));
        chk("z0_fwdData", 32'(f0_d), 32'(e.d));
        chk("z1_fwdValid", 32'(f1_v), 32'(e.we1));
`endif
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; in_valid = 1'b0; RegWrite = 1'b0; RegStore = 2'd0; LoadSize = 2'd0;
    IPCP2 = '0; ALUResult = '0; StoreMem = '0; Imm = '0; mem_valid = 1'b0; rdWB = '0;
    m_pend = 1'b0; m_pend_rd = '0; m_pend_rw = 1'b0; m_pend_ls = '0;
    m_data = '0; m_addr = '0; m_we = 1'b0;

    // Reset held with an ALU op presented
    drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 16'h0, 16'hAAAA, 16'h0, 16'h0, 1'b0, 3'd5);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 16'h0, 16'hAAAA, 16'h0, 16'h0, 1'b0, 3'd5);
    // ALU path, then forced link write
    drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 16'h0, 16'hAAAA, 16'h0, 16'h0, 1'b0, 3'd5);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 16'hCCCC, 16'h0, 16'h0, 16'h0, 1'b0, 3'd7);
    idle_cycle();
    // Late sign-extended load
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd3);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 16'h0, 16'h5555, 16'h0, 16'h0, 1'b0, 3'd6);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h12F0, 16'h0, 1'b1, 3'd0);
    idle_cycle();
    // Reset while waiting for memory; stall must clear without a clock edge
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd4);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 3'd0);
    #1;
    chk("async_reset_stall_z0", 32'(d0_stall), 32'd0);
    chk("async_reset_stall_z1", 32'(d1_stall), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h00FF, 16'h0, 1'b1, 3'd0);
    // Write to register 0, and a zero-extended load hitting immediately
    drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 16'h0, 16'h1234, 16'h0, 16'h0, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 16'h0, 16'h0, 16'hBE8F, 16'h0, 1'b1, 3'd2);
    drive(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 16'h0, 16'h0, 16'h0, 16'h7700, 1'b0, 3'd1);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 16'h0, 16'h0, 16'h8081, 16'h0, 1'b1, 3'd6);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
            2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom));
    end
    idle_cycle();

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/write_stage_param.md
Name: write_stage_param

Overview:
- Parametrised next-generation writeback stage.
- Selects the result to write from ALU, load data, link address (PC+2) or immediate.
- Sizes and extends load data, then drives a registered write port into the register file.
- Adds a valid/stall handshake for late load data, optional zero-register suppression, and an optional forwarding port. Sits between the memory stage and the register file.

Parameters:
DATA_W, 16, datapath width in bits (>= 8)
ADDR_W, 3, register address width
ZERO_REG, 0, 1 = writes to register 0 are suppressed (regWriteOut forced 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  memory stage presents a valid op this cycle
RegWrite  in  1  op writes a register
RegStore  in  2  source select: 0 StoreMem, 1 ALUResult, 2 IPCP2 (link), 3 Imm
LoadSize  in  2  0 full word, 1 low byte zero-ext, 2 low byte sign-ext, 3 treated as 0
IPCP2  in  DATA_W  PC+2 link value
ALUResult  in  DATA_W  ALU result
StoreMem  in  DATA_W  load data from memory
Imm  in  DATA_W  immediate (LUI-style)
mem_valid  in  1  StoreMem is valid this cycle
rdWB  in  ADDR_W  destination register
loadData  out  DATA_W  write data to register file
loadAddr  out  ADDR_W  write address
regWriteOut  out  1  write strobe, one cycle per retired op
stall  out  1  upstream must hold its op
fwdValid/fwdAddr/fwdData  out  1/ADDR_W/DATA_W  forwarding port (WB_FORWARD_EN only)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - loadData, loadAddr, regWriteOut and stall go to 0.
  - Forward outputs go to 0.
  - Takes effect mid-WAIT_MEM too; the captured op is discarded.
- FSM states: IDLE, WAIT_MEM.
- IDLE, in_valid=0:
  - regWriteOut=0 at the next edge; loadData and loadAddr hold their values.
- IDLE, in_valid=1, and either RegStore!=0 or mem_valid=1:
  - Retire at the next edge: loadData=selected/extended value, loadAddr=rdWB.
  - regWriteOut=RegWrite, except when RegStore=2, which forces 1 (link always writes).
  - Latency is 1 cycle.
- IDLE, in_valid=1, RegStore=0, mem_valid=0:
  - Capture rdWB, RegWrite and LoadSize; go to WAIT_MEM.
  - stall=1 from the next edge; regWriteOut=0.
- WAIT_MEM:
  - stall stays 1; in_valid and the other op inputs are ignored.
  - On mem_valid=1: retire with the captured rd, RegWrite and LoadSize and the current StoreMem; stall=0 and return to IDLE at the same edge.
  - No timeout.
- stall is a registered output. It is 1 exactly for the cycles spent in WAIT_MEM.
- Extension applies only when RegStore=0:
  - Zero-extend: upper DATA_W-8 bits are 0.
  - Sign-extend: upper bits replicate StoreMem[7].
- ZERO_REG=1 and the retired address is 0: regWriteOut=0; loadData and loadAddr still update.
- Simultaneous reset and mem_valid: reset wins.
- Back-to-back retires are allowed every cycle in IDLE.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - fwdValid/fwdAddr/fwdData are combinational copies of regWriteOut/loadAddr/loadData.
  - fwdValid is additionally qualified so it is 0 whenever regWriteOut=0.
  - Lets the decode stage bypass the register file in the same cycle.
- Not defined: the forward ports are absent from the module and no related logic is synthesised.

Test Plan:
- Reset: reset=0 with inputs {in_valid=1, RegWrite=1, RegStore=1, ALUResult=0xAAAA, rdWB=5} -> loadData=0, loadAddr=0, regWriteOut=0, stall=0.
- ALU path: release reset, RegStore=1, ALUResult=0xAAAA, rdWB=5 -> 1 cycle later loadData=0xAAAA, loadAddr=5, regWriteOut=1.
- Link path: RegStore=2, RegWrite=0, IPCP2=0xCCCC, rdWB=7 -> loadData=0xCCCC, regWriteOut=1 (forced).
- Late load:
  - Stimulus: RegStore=0, LoadSize=2, rdWB=3, mem_valid=0 for 2 cycles, then mem_valid=1 with StoreMem=0x12F0.
  - Response: stall=1 for 2 cycles; then loadData=0xFFF0, loadAddr=3, regWriteOut=1, stall=0.
- Reset mid-wait: enter WAIT_MEM, assert reset=0 before mem_valid -> stall=0 immediately; no write on release even if mem_valid=1.
- ZERO_REG=1: RegWrite=1, RegStore=1, rdWB=0, ALUResult=0x1234 -> regWriteOut=0, loadData=0x1234; with WB_FORWARD_EN, fwdValid=0.
